// File: rtl/mmk_mul_pipe.sv
// mmk_mul_pipe: pipelined signed/unsigned multiplier with valid/ready flow control and tag sideband; define MMK_MUL_PIPE_SAT_EN to clamp narrow results
module mmk_mul_pipe #(
    parameter int DIN0_W    = 24,
    parameter int DIN1_W    = 32,
    parameter int DOUT_W    = 55,
    parameter int NUM_STAGE = 3,
    parameter int TAG_W     = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [DIN0_W-1:0] din0,
    input  logic [DIN1_W-1:0] din1,
    input  logic              din_signed,
    input  logic [TAG_W-1:0]  din_tag,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DOUT_W-1:0] dout,
    output logic [TAG_W-1:0]  dout_tag,
    output logic              dout_sat
);
    localparam int P = DIN0_W + DIN1_W;

    if (NUM_STAGE < 1) begin : g_bad_depth
        $error("mmk_mul_pipe: NUM_STAGE must be >= 1");
    end

    logic                 w_ce;
    logic [P-1:0]         w_a;
    logic [P-1:0]         w_b;
    logic [P-1:0]         w_prod;
    logic [P-1:0]         w_last;
    logic                 w_sgn_last;
    logic [NUM_STAGE-1:0] r_vld;
    logic [NUM_STAGE-1:0] r_sgn;
    logic [P-1:0]         r_prod [NUM_STAGE];
    logic [TAG_W-1:0]     r_tag  [NUM_STAGE];

    assign w_ce      = dout_ready | ~dout_valid;
    assign din_ready = w_ce;
    // Low P bits of the product of the extended operands are exact in both modes
    assign w_a       = din_signed ? P'($signed(din0)) : P'(din0);
    assign w_b       = din_signed ? P'($signed(din1)) : P'(din1);
    assign w_prod    = w_a * w_b;

    // Global-stall pipeline: every stage shifts together on ce, otherwise all hold
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_vld <= '0;
            r_sgn <= '0;
            for (int s = 0; s < NUM_STAGE; s++) begin
                r_prod[s] <= '0;
                r_tag[s]  <= '0;
            end
        end else if (w_ce) begin
            r_vld[0]  <= din_valid;
            r_sgn[0]  <= din_signed;
            r_prod[0] <= w_prod;
            r_tag[0]  <= din_tag;
            for (int s = 1; s < NUM_STAGE; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_sgn[s]  <= r_sgn[s-1];
                r_prod[s] <= r_prod[s-1];
                r_tag[s]  <= r_tag[s-1];
            end
        end
    end

    assign dout_valid = r_vld[NUM_STAGE-1];
    assign dout_tag   = r_tag[NUM_STAGE-1];
    assign w_last     = r_prod[NUM_STAGE-1];
    assign w_sgn_last = r_sgn[NUM_STAGE-1];

    if (DOUT_W < P) begin : g_narrow
`ifdef MMK_MUL_PIPE_SAT_EN
        localparam logic [DOUT_W-1:0] MIN_S = DOUT_W'(1) << (DOUT_W - 1);
        logic [P-DOUT_W:0] w_hi;
        logic              w_ovf;
        assign w_hi     = w_last[P-1:DOUT_W-1];
        assign w_ovf    = w_sgn_last ? ~(&w_hi | ~|w_hi) : |w_last[P-1:DOUT_W];
        assign dout_sat = w_ovf;
        assign dout     = !w_ovf ? w_last[DOUT_W-1:0] :
                          w_sgn_last ? (w_last[P-1] ? MIN_S : ~MIN_S) : '1;
`else
        assign dout     = w_last[DOUT_W-1:0];
        assign dout_sat = 1'b0;
`endif
    end else begin : g_wide
        assign dout     = w_sgn_last ? DOUT_W'($signed(w_last)) : DOUT_W'(w_last);
        assign dout_sat = 1'b0;
    end
endmodule

// File: tb/tb_mmk_mul_pipe.sv
// tb_mmk_mul_pipe: directed checks of mmk_mul_pipe latency, arithmetic, flow control and reset
module tb_mmk_mul_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic        din_signed = 1'b0;
  logic        dout_ready = 1'b1;
  logic [23:0] din0 = '0;
  logic [31:0] din1 = '0;
  logic [7:0]  din_tag = '0;
  logic        din_ready, dout_valid, dout_sat;
  logic [54:0] dout;
  logic [7:0]  dout_tag;
  logic        s1_ready, s1_valid, s1_sat, s5_ready, s5_valid, s5_sat;
  logic [59:0] s1_dout, s5_dout;
  logic [7:0]  s1_tag, s5_tag;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_emit  = 0;
  logic [63:0] q[$];
  logic        hold = 1'b0;
  logic [63:0] hold_val;

  always #5 clk = ~clk;

  mmk_mul_pipe u_dut (
    .ap_clk(clk), .ap_rst(rst), .din_valid(din_valid), .din_ready(din_ready),
    .din0(din0), .din1(din1), .din_signed(din_signed), .din_tag(din_tag),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .dout_tag(dout_tag), .dout_sat(dout_sat)
  );

  mmk_mul_pipe #(.NUM_STAGE(1), .DOUT_W(60)) u_s1 (
    .ap_clk(clk), .ap_rst(rst), .din_valid(din_valid), .din_ready(s1_ready),
    .din0(din0), .din1(din1), .din_signed(din_signed), .din_tag(din_tag),
    .dout_valid(s1_valid), .dout_ready(dout_ready), .dout(s1_dout),
    .dout_tag(s1_tag), .dout_sat(s1_sat)
  );

  mmk_mul_pipe #(.NUM_STAGE(5), .DOUT_W(60)) u_s5 (
    .ap_clk(clk), .ap_rst(rst), .din_valid(din_valid), .din_ready(s5_ready),
    .din0(din0), .din1(din1), .din_signed(din_signed), .din_tag(din_tag),
    .dout_valid(s5_valid), .dout_ready(dout_ready), .dout(s5_dout),
    .dout_tag(s5_tag), .dout_sat(s5_sat)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_ent(input logic [23:0] a, input logic [31:0] b,
                                          input logic s, input logic [7:0] t);
    longint p;
    logic   sat;
    p   = s ? longint'($signed(a)) * longint'($signed(b))
            : longint'({40'd0, a}) * longint'({32'd0, b});
    sat = 1'b0;
`ifdef MMK_MUL_PIPE_SAT_EN
    if (s && p > 64'sh3F_FFFF_FFFF_FFFF) begin p = 64'sh3F_FFFF_FFFF_FFFF; sat = 1'b1; end
    else if (s && p < -64'sh40_0000_0000_0000) begin p = -64'sh40_0000_0000_0000; sat = 1'b1; end
    else if (!s && p > 64'sh7F_FFFF_FFFF_FFFF) begin p = 64'sh7F_FFFF_FFFF_FFFF; sat = 1'b1; end
`endif
    return {sat, t, p[54:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [23:0] a, input logic [31:0] b,
                     input logic s, input logic [7:0] t, input logic r, output logic acc);
    logic [63:0] e;
    if (hold) chk("hold_stable", {dout_sat, dout_tag, dout}, hold_val);
    hold = 1'b0;
    din_valid = v; din0 = a; din1 = b; din_signed = s; din_tag = t; dout_ready = r;
    #1;
    acc = v && din_ready;
    if (dout_valid && dout_ready) begin
      e = (q.size() > 0) ? q.pop_front() : 'x;
      chk("sb_result", {dout_sat, dout_tag, dout}, e);
      n_emit++;
    end
    if (dout_valid && !dout_ready) begin
      chk("stall_din_ready", din_ready, 1'b0);
      hold = 1'b1;
      hold_val = {dout_sat, dout_tag, dout};
    end
    if (acc) q.push_back(ref_ent(a, b, s, t));
    tick();
  endtask

  initial begin
    logic        acc;
    int          bi, e0;
    logic [23:0] va [10];
    logic [31:0] vb [10];
    tick(); tick();
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_dout", dout, 55'h0);
    chk("rst_tag", dout_tag, 8'h0);
    chk("rst_sat", dout_sat, 1'b0);
    chk("rst_din_ready", din_ready, 1'b1);
    rst = 1'b0;
    tick();
    cyc(1, 24'h000011, 32'h22, 0, 8'h01, 1, acc);
    cyc(1, 24'h000033, 32'h44, 1, 8'h02, 1, acc);
    cyc(1, 24'h000055, 32'h66, 0, 8'h03, 1, acc);
    chk("pre_rst_valid", dout_valid, 1'b1);
    rst = 1'b1;
    din_valid = 1'b0;
    #1;
    chk("mid_rst_valid", dout_valid, 1'b0);
    chk("mid_rst_dout", dout, 55'h0);
    chk("mid_rst_tag", dout_tag, 8'h0);
    chk("mid_rst_din_ready", din_ready, 1'b1);
    q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, '0, '0, 0, '0, 1, acc);
      chk("post_rst_no_stale", dout_valid, 1'b0);
    end
    din_valid = 1; din0 = 24'hFFFFFF; din1 = 32'hFFFFFFFF; din_signed = 0; din_tag = 8'h5A;
    dout_ready = 1;
    tick();
    din_valid = 0;
    chk("lat_edge_k", dout_valid, 1'b0);
    tick();
    chk("lat_edge_k1", dout_valid, 1'b0);
    tick();
    chk("lat_edge_k2", dout_valid, 1'b1);
`ifdef MMK_MUL_PIPE_SAT_EN
    chk("u_max_dout", dout, 55'h7FFFFFFFFFFFFF);
    chk("u_max_sat", dout_sat, 1'b1);
`else
    chk("u_max_dout", dout, 55'h7FFFFEFF000001);
    chk("u_max_sat", dout_sat, 1'b0);
`endif
    chk("u_max_tag", dout_tag, 8'h5A);
    tick();
    chk("u_max_drain", dout_valid, 1'b0);
    din_valid = 1; din0 = 24'hFFFFFF; din1 = 32'hFFFFFFFF; din_signed = 1; din_tag = 8'hA1;
    tick();
    din0 = 24'h800000; din1 = 32'h80000000; din_tag = 8'hB2;
    tick();
    din_valid = 0;
    tick();
    chk("s_a_valid", dout_valid, 1'b1);
    chk("s_a_dout", dout, 55'h1);
    chk("s_a_tag", dout_tag, 8'hA1);
    tick();
    chk("s_b_valid", dout_valid, 1'b1);
`ifdef MMK_MUL_PIPE_SAT_EN
    chk("s_b_dout", dout, 55'h3FFFFFFFFFFFFF);
    chk("s_b_sat", dout_sat, 1'b1);
`else
    chk("s_b_dout", dout, 55'h40000000000000);
    chk("s_b_sat", dout_sat, 1'b0);
`endif
    chk("s_b_tag", dout_tag, 8'hB2);
    tick();
    e0 = n_emit;
    for (int i = 0; i < 100; i++) begin
      if (i >= 3) chk("stream_full_rate", dout_valid, 1'b1);
      cyc(1, 24'($urandom), $urandom, i[0], 8'(i), 1, acc);
      chk("stream_accept", acc, 1'b1);
    end
    for (int i = 0; i < 5; i++) cyc(0, '0, '0, 0, '0, 1, acc);
    chk("stream_count", n_emit - e0, 100);
    chk("stream_q_empty", q.size(), 0);
    for (int i = 0; i < 10; i++) begin
      va[i] = 24'($urandom);
      vb[i] = $urandom;
    end
    e0 = n_emit;
    bi = 0;
    for (int c = 0; c < 40 && (bi < 10 || q.size() > 0); c++) begin
      if (bi < 10) cyc(1, va[bi], vb[bi], bi[0], 8'(8'h80 + bi), !(c >= 4 && c < 9), acc);
      else cyc(0, '0, '0, 0, '0, 1, acc);
      if (acc) bi++;
    end
    chk("bp_all_sent", bi, 10);
    chk("bp_count", n_emit - e0, 10);
    chk("bp_q_empty", q.size(), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din_valid = 1; din0 = 24'hFFFFFD; din1 = 32'd7; din_signed = 1; din_tag = 8'h3C;
    dout_ready = 1;
    tick();
    din0 = 24'hFFFFFF; din1 = 32'hFFFFFFFF; din_signed = 0; din_tag = 8'h3D;
    chk("s1_valid", s1_valid, 1'b1);
    chk("s1_dout", s1_dout, 60'hFFFFFFFFFFFFFEB);
    chk("s1_tag", s1_tag, 8'h3C);
    chk("s5_valid_0", s5_valid, 1'b0);
    tick();
    din_valid = 0;
    chk("s1_u_dout", s1_dout, 60'h0FFFFFEFF000001);
    chk("s5_valid_1", s5_valid, 1'b0);
    tick();
    chk("s1_drain", s1_valid, 1'b0);
    chk("s5_valid_2", s5_valid, 1'b0);
    tick();
    chk("s5_valid_3", s5_valid, 1'b0);
    tick();
    chk("s5_valid_4", s5_valid, 1'b1);
    chk("s5_dout", s5_dout, 60'hFFFFFFFFFFFFFEB);
    chk("s5_sat", s5_sat, 1'b0);
    tick();
    chk("s5_u_dout", s5_dout, 60'h0FFFFFEFF000001);
    chk("s5_u_tag", s5_tag, 8'h3D);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
